card_dealer: RTL and testbench

- Upstream stimulus stage for the poker win-rate block.
- Deals 21 unique cards from a 52-card deck using a seeded 16-bit LFSR with linear-probe collision resolution: 9 players × 2 hole cards plus 3 public cards.
- Presents the cards as one packed, single-cycle valid beat in exactly the input format the win-rate block consumes.
- Serves as the on-chip pattern source for self-test.

---
 rtl/poker_pkg.sv | 35 +++
 rtl/deal_lfsr.sv | 25 ++
 rtl/card_dealer.sv | 156 +++++++++++++++
 tb/tb_card_dealer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poker_pkg.sv
// Shared deck constants, dealer state encoding and card-index decoding.
// Pure declarations, no timing.
// No flow control.
package poker_pkg;

    localparam int DECK_SIZE   = 52;
    localparam int NUM_PLAYERS = 9;
    localparam int NUM_PUB     = 3;
    localparam int NUM_SLOTS   = 2 * NUM_PLAYERS + NUM_PUB;
    localparam int RANK_W      = 4;
    localparam int SUIT_W      = 2;
    localparam int CARD_W      = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_PROBE,
        ST_WAIT,
        ST_EMIT
    } deal_state_t;

    typedef struct packed {
        logic [RANK_W-1:0] rank;
        logic [SUIT_W-1:0] suit;
    } card_t;

    // Index k in 0..51: rank 2..14 (Ace high), suit 0..3.
    function automatic card_t card_to_rank_suit(input logic [CARD_W-1:0] k);
        card_t c;
        c.rank = k[5:2] + 4'd2;
        c.suit = k[1:0];
        return c;
    endfunction

endpackage

// File: rtl/deal_lfsr.sv
// 16-bit Fibonacci LFSR (taps 15,13,12,10) with synchronous load.
// State updates one cycle after load/adv; load has priority over adv.
// No flow control; the owner gates adv.
module deal_lfsr #(
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        adv,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RESET_VAL;
        end else if (load) begin
            state <= load_val;
        end else if (adv) begin
            state <= {state[14:0], state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Deals 21 distinct cards (9 players x 2 + 3 public) from an LFSR with linear probing.
// 22 cycles from start to out_valid with no collisions, +1 per probe cycle.
// Holds the finished deal in WAIT until down_ready; start is ignored while busy.
module card_dealer #(
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1,
    parameter int          NUM_PLAYERS  = 9,
    parameter int          NUM_PUB      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic        down_ready,
    output logic        busy,
    output logic        out_valid,
    output logic [71:0] out_hole_num,
    output logic [35:0] out_hole_suit,
    output logic [11:0] out_pub_num,
    output logic [5:0]  out_pub_suit
);

    import poker_pkg::*;

    localparam int          NSLOTS    = 2 * NUM_PLAYERS + NUM_PUB;
    localparam logic [4:0]  LAST_SLOT = 5'(NSLOTS - 1);
    localparam logic [5:0]  LAST_CARD = 6'(DECK_SIZE - 1);

    deal_state_t            state;
    logic [4:0]             slot;
    logic [5:0]             probe;
    logic [DECK_SIZE-1:0]   used;
    logic [CARD_W-1:0]      cards [NSLOTS];

    logic [15:0] lfsr_state;
    logic        lfsr_load;
    logic        lfsr_adv;
    logic [15:0] lfsr_load_val;
    logic        lfsr_unused;
    logic [5:0]  raw;
    logic [5:0]  cand;
    logic [5:0]  pick;
    logic [5:0]  pick_next;

    logic [71:0] hole_num_n;
    logic [35:0] hole_suit_n;
    logic [11:0] pub_num_n;
    logic [5:0]  pub_suit_n;
    card_t       c1;
    card_t       c2;
    card_t       cp;

    assign lfsr_load     = (state == ST_IDLE) && start;
    assign lfsr_adv      = (state == ST_DRAW);
    assign lfsr_load_val = (seed == 16'd0) ? DEFAULT_SEED : seed;
    assign lfsr_unused   = ^lfsr_state[15:6];

    deal_lfsr #(
        .RESET_VAL (DEFAULT_SEED)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .adv      (lfsr_adv),
        .state    (lfsr_state)
    );

    // Candidate comes from the pre-advance LFSR value, folded into 0..51.
    assign raw       = lfsr_state[5:0];
    assign cand      = (raw >= 6'(DECK_SIZE)) ? raw - 6'(DECK_SIZE) : raw;
    assign pick      = (state == ST_DRAW) ? cand : probe;
    assign pick_next = (pick == LAST_CARD) ? 6'd0 : pick + 6'd1;

    // Slot 2*(NUM_PLAYERS-1-p) is player p card1; public cards follow the hole cards.
    always_comb begin
        hole_num_n  = '0;
        hole_suit_n = '0;
        pub_num_n   = '0;
        pub_suit_n  = '0;
        c1          = '0;
        c2          = '0;
        cp          = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            c1 = card_to_rank_suit(cards[2*(NUM_PLAYERS-1-p)]);
            c2 = card_to_rank_suit(cards[2*(NUM_PLAYERS-1-p)+1]);
            hole_num_n[p*8 +: 8]  = {c1.rank, c2.rank};
            hole_suit_n[p*4 +: 4] = {c1.suit, c2.suit};
        end
        for (int j = 0; j < NUM_PUB; j++) begin
            cp = card_to_rank_suit(cards[2*NUM_PLAYERS+j]);
            pub_num_n[(NUM_PUB-1-j)*4 +: 4]  = cp.rank;
            pub_suit_n[(NUM_PUB-1-j)*2 +: 2] = cp.suit;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            slot          <= '0;
            probe         <= '0;
            used          <= '0;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            out_hole_num  <= '0;
            out_hole_suit <= '0;
            out_pub_num   <= '0;
            out_pub_suit  <= '0;
            for (int s = 0; s < NSLOTS; s++) begin
                cards[s] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        used  <= '0;
                        slot  <= '0;
                        busy  <= 1'b1;
                        state <= ST_DRAW;
                    end
                end
                ST_DRAW, ST_PROBE: begin
                    if (!used[pick]) begin
                        cards[slot] <= pick;
                        used[pick]  <= 1'b1;
                        slot        <= slot + 5'd1;
                        state       <= (slot == LAST_SLOT) ? ST_WAIT : ST_DRAW;
                    end else begin
                        probe <= pick_next;
                        state <= ST_PROBE;
                    end
                end
                ST_WAIT: begin
                    if (down_ready) begin
                        out_hole_num  <= hole_num_n;
                        out_hole_suit <= hole_suit_n;
                        out_pub_num   <= pub_num_n;
                        out_pub_suit  <= pub_suit_n;
                        out_valid     <= 1'b1;
                        state         <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    out_valid     <= 1'b0;
                    out_hole_num  <= '0;
                    out_hole_suit <= '0;
                    out_pub_num   <= '0;
                    out_pub_suit  <= '0;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Randomized scoreboard bench for card_dealer against a deck/array reference model.
module tb_card_dealer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] seed;
    logic        down_ready;
    logic        busy;
    logic        out_valid;
    logic [71:0] out_hole_num;
    logic [35:0] out_hole_suit;
    logic [11:0] out_pub_num;
    logic [5:0]  out_pub_suit;

    card_dealer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seed          (seed),
        .down_ready    (down_ready),
        .busy          (busy),
        .out_valid     (out_valid),
        .out_hole_num  (out_hole_num),
        .out_hole_suit (out_hole_suit),
        .out_pub_num   (out_pub_num),
        .out_pub_suit  (out_pub_suit)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] hn;
        logic [35:0] hs;
        logic [11:0] pn;
        logic [5:0]  ps;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          start_cyc = 0;
    int          done_cnt  = 0;
    int          max_lat   = 0;
    logic        prev_v    = 1'b0;
    logic [71:0] last_hn;
    logic [35:0] last_hs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Deal by the rules on a plain deck array; count one cycle per draw or probe attempt.
    function automatic void model(input logic [15:0] sd, output exp_t e);
        bit          used[52];
        int          cards[21];
        logic [15:0] l;
        int          cand, n, p, rk, st;
        for (int i = 0; i < 52; i++) used[i] = 1'b0;
        l = (sd == 16'd0) ? 16'hACE1 : sd;
        n = 0;
        for (int s = 0; s < 21; s++) begin
            cand = int'(l[5:0]);
            if (cand >= 52) cand -= 52;
            l = lfsr_next(l);
            n++;
            while (used[cand]) begin
                cand = (cand + 1) % 52;
                n++;
            end
            used[cand] = 1'b1;
            cards[s]   = cand;
        end
        e.hn = '0; e.hs = '0; e.pn = '0; e.ps = '0;
        for (int s = 0; s < 21; s++) begin
            rk = cards[s] / 4 + 2;
            st = cards[s] % 4;
            if (s < 18) begin
                p = 8 - s / 2;
                if (s % 2 == 0) begin
                    e.hn[p*8+4 +: 4] = 4'(rk);
                    e.hs[p*4+2 +: 2] = 2'(st);
                end else begin
                    e.hn[p*8 +: 4] = 4'(rk);
                    e.hs[p*4 +: 2] = 2'(st);
                end
            end else begin
                e.pn[(20-s)*4 +: 4] = 4'(rk);
                e.ps[(20-s)*2 +: 2] = 2'(st);
            end
        end
        e.lat = n + 1;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a deal.
    always @(negedge clk) begin
        exp_t e;
        bit   seen[52];
        bit   dup;
        int   rk, st, idx, lat;
        if (!rst) begin
            if (prev_v) begin
                chk("valid_single_cycle", 72'(out_valid), 72'd0);
                chk("busy_clear_after_emit", 72'(busy), 72'd0);
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 expected no deal pending");
                end else begin
                    e = sb.pop_front();
                    chk("hole_num", out_hole_num, e.hn);
                    chk("hole_suit", 72'(out_hole_suit), 72'(e.hs));
                    chk("pub_num", 72'(out_pub_num), 72'(e.pn));
                    chk("pub_suit", 72'(out_pub_suit), 72'(e.ps));
                    lat = cyc - start_cyc;
                    if (e.lat >= 0) begin
                        chk("latency", 72'(lat), 72'(e.lat));
                        if (lat > max_lat) max_lat = lat;
                    end
                    for (int i = 0; i < 52; i++) seen[i] = 1'b0;
                    dup = 1'b0;
                    for (int s = 0; s < 21; s++) begin
                        if (s < 18) begin
                            rk = int'(out_hole_num[(8 - s/2)*8 + ((s % 2 == 0) ? 4 : 0) +: 4]);
                            st = int'(out_hole_suit[(8 - s/2)*4 + ((s % 2 == 0) ? 2 : 0) +: 2]);
                        end else begin
                            rk = int'(out_pub_num[(20-s)*4 +: 4]);
                            st = int'(out_pub_suit[(20-s)*2 +: 2]);
                        end
                        if (rk < 2 || rk > 14) begin
                            dup = 1'b1;
                        end else begin
                            idx = (rk - 2) * 4 + st;
                            if (seen[idx]) dup = 1'b1;
                            seen[idx] = 1'b1;
                        end
                    end
                    chk("cards_distinct", 72'(dup), 72'd0);
                    last_hn = out_hole_num;
                    last_hs = out_hole_suit;
                    done_cnt++;
                end
            end
        end
        prev_v <= out_valid && !rst;
    end

    task automatic issue(input logic [15:0] sd, input bit lat_ok);
        exp_t e;
        model(sd, e);
        if (!lat_ok) e.lat = -1;
        @(negedge clk);
        start = 1'b1;
        seed  = sd;
        sb.push_back(e);
        @(posedge clk);
        #1 start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0);
        for (int i = 0; i < 3000 && done_cnt == n0; i++) @(negedge clk);
        checks++;
        if (done_cnt == n0) begin
            errors++;
            $display("FAIL deal_timeout: got no out_valid within 3000 cycles expected one deal");
            sb.delete();
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_busy"}, 72'(busy), 72'd0);
        chk({tag, "_valid"}, 72'(out_valid), 72'd0);
        chk({tag, "_hole_num"}, out_hole_num, 72'd0);
        chk({tag, "_hole_suit"}, 72'(out_hole_suit), 72'd0);
        chk({tag, "_pub"}, 72'({out_pub_num, out_pub_suit}), 72'd0);
    endtask

    initial begin
        int   n0, bad;
        exp_t e;
        rst = 1'b1; start = 1'b0; seed = '0; down_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero_outputs("post_reset");

        // seed 0 falls back to 0xACE1: slot0 = card 33, slot1 = card 3
        n0 = done_cnt;
        issue(16'h0000, 1'b1);
        wait_done(n0);
        chk("seed0_p8c1_rank", 72'(last_hn[71:68]), 72'd10);
        chk("seed0_p8c1_suit", 72'(last_hs[35:34]), 72'd1);
        chk("seed0_p8c2_rank", 72'(last_hn[67:64]), 72'd2);
        chk("seed0_p8c2_suit", 72'(last_hs[33:32]), 72'd3);

        // candidate 63 folds to 11
        n0 = done_cnt;
        issue(16'h003F, 1'b1);
        wait_done(n0);
        chk("seed3f_p8c1_rank", 72'(last_hn[71:68]), 72'd4);
        chk("seed3f_p8c1_suit", 72'(last_hs[35:34]), 72'd3);

        // Downstream stall: must hold in WAIT with buses at zero
        seed = 16'(($urandom_range(65535, 1)));
        model(seed, e);
        down_ready = 1'b0;
        n0 = done_cnt;
        issue(seed, 1'b0);
        bad = 0;
        repeat (e.lat - 1 + 50) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b1 || out_hole_num !== 72'd0) bad++;
        end
        chk("stall_hold", 72'(bad), 72'd0);
        down_ready = 1'b1;
        @(posedge clk);
        #1 chk("stall_release_valid", 72'(out_valid), 72'd1);
        wait_done(n0);

        // start pulses while busy are ignored
        n0 = done_cnt;
        issue(16'(($urandom_range(65535, 1))), 1'b1);
        @(negedge clk);
        start = 1'b1; seed = 16'(($urandom_range(65535, 1)));
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1; seed = 16'(($urandom_range(65535, 1)));
        @(negedge clk);
        start = 1'b0;
        wait_done(n0);
        repeat (40) @(negedge clk);
        chk("ignored_start_idle", 72'(busy), 72'd0);

        // reset mid-deal, then a fresh deal must carry no residue
        issue(16'(($urandom_range(65535, 1))), 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1 chk_zero_outputs("mid_reset");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        n0 = done_cnt;
        issue(16'(($urandom_range(65535, 1))), 1'b1);
        wait_done(n0);

        for (int i = 0; i < 2000; i++) begin
            n0 = done_cnt;
            issue(16'(($urandom_range(65535, 1))), 1'b1);
            wait_done(n0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 72'(sb.size()), 72'd0);
        $display("max deal latency: %0d cycles", max_lat);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
